// File: rtl/fc_layer_pkg.sv
// Shared types and helpers for the fully-connected layer master.
// State codes, output mode constants and a width-generic saturating add.
package fc_layer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    MAC     = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int BIN_SAT  = 0;
  localparam int BIN_SIGN = 1;

  // Adds two sign-extended operands and clamps to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [64:0] s;
    logic signed [64:0] mx;
    logic signed [64:0] mn;
    s  = 65'(a) + 65'(b);
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -(65'sd1 <<< (w - 1));
    if (s > mx)
      return 64'(mx);
    else if (s < mn)
      return 64'(mn);
    else
      return 64'(s);
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Accumulator for one neuron: gated saturating MAC on weights,
// bias add with threshold or saturation on the closing bias word.
module fc_mac_unit
  import fc_layer_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ACC_W        = 24,
  parameter int BINARIZE_OUT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              valid,
  input  logic              is_bias,
  input  logic              in_bit,
  input  logic [DATA_W-1:0] data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    sum = ACC_W'(sat_add(64'(acc), 64'($signed(data)), ACC_W));
    out_valid = valid && is_bias;
    if (BINARIZE_OUT == BIN_SIGN)
      out_data = sum[ACC_W-1] ? '0 : DATA_W'(1);
    else
      out_data = DATA_W'(sat_add(64'(sum), 64'sd0, DATA_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (valid) begin
      if (is_bias)
        acc <= '0;
      else if (in_bit)
        acc <= sum;
    end
  end

endmodule

// File: rtl/fc_layer_master.sv
// Avalon-MM master computing one fully-connected layer with binary inputs.
// Pipelined reads with bounded outstanding count; results written back.
module fc_layer_master
  import fc_layer_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 32,
  parameter int N_IN            = 784,
  parameter int N_OUT           = 200,
  parameter int ACC_W           = 24,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BINARIZE_OUT    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   in_base,
  input  logic [ADDR_W-1:0]   w_base,
  input  logic [ADDR_W-1:0]   b_base,
  input  logic [ADDR_W-1:0]   out_base,
  output logic                busy,
  output logic                done,
  output logic [2:0]          s,
  output logic [ADDR_W-1:0]   address,
  output logic                chipselect,
  output logic                read_n,
  output logic                write_n,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                readdatavalid,
  output logic [DATA_W-1:0]   writedata
);

  localparam int CW = $clog2(N_IN + 1);
  localparam int RW = $clog2(N_OUT + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] NI  = CW'(N_IN);
  localparam logic [CW-1:0] NI1 = CW'(N_IN - 1);
  localparam logic [RW-1:0] NO  = RW'(N_OUT);
  localparam logic [RW-1:0] NO1 = RW'(N_OUT - 1);
  localparam logic [OW-1:0] MO  = OW'(MAX_OUTSTANDING);

  state_t state, nstate;

  logic [ADDR_W-1:0] in_ptr, w_ptr, b_ptr, o_ptr;
  logic [CW-1:0]     i_col, r_col;
  logic [RW-1:0]     i_row, r_row, w_idx;
  logic [OW-1:0]     outstanding;
  logic [(1<<CW)-1:0] in_bits;
  logic [DATA_W-1:0] out_buf [1<<RW];

  logic              rd_pend, rd_acc, rv, wr_acc;
  logic              is_bias, in_bit, mac_v, mac_ov;
  logic [DATA_W-1:0] mac_out;

  assign chipselect = 1'b1;
  assign byteenable = '1;
  assign s          = state;

  always_comb begin
    rd_pend = (state == LOAD_IN && i_col != NI) ||
              (state == MAC && i_row != NO);
    read_n  = !(rd_pend && outstanding < MO);
    rd_acc  = !read_n && !waitrequest;
    rv      = readdatavalid && outstanding != '0 &&
              (state == LOAD_IN || state == MAC);
    is_bias = r_col == NI;
    in_bit  = in_bits[r_col];
    mac_v   = rv && state == MAC;
    write_n = state != WRITE;
    wr_acc  = !write_n && !waitrequest;
    busy    = state == LOAD_IN || state == MAC || state == WRITE;
    done    = state == DONE;
  end

  always_comb begin
    address   = '0;
    writedata = '0;
    unique case (1'b1)
      state == LOAD_IN: address = in_ptr;
      state == MAC:     address = is_bias_issue() ? b_ptr : w_ptr;
      state == WRITE: begin
        address   = o_ptr;
        writedata = out_buf[w_idx];
      end
      default: ;
    endcase
  end

  function automatic logic is_bias_issue();
    return i_col == NI;
  endfunction

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (start) nstate = LOAD_IN;
      LOAD_IN: if (rv && r_col == NI1) nstate = MAC;
      MAC:     if (r_row == NO && outstanding == '0) nstate = WRITE;
      WRITE:   if (wr_acc && w_idx == NO1) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ptr      <= '0;
      w_ptr       <= '0;
      b_ptr       <= '0;
      o_ptr       <= '0;
      i_col       <= '0;
      r_col       <= '0;
      i_row       <= '0;
      r_row       <= '0;
      w_idx       <= '0;
      outstanding <= '0;
      in_bits     <= '0;
    end else begin
      state <= nstate;
      unique case ({rd_acc, rv})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (state == IDLE && start) begin
        in_ptr <= in_base;
        w_ptr  <= w_base;
        b_ptr  <= b_base;
        o_ptr  <= out_base;
        i_col  <= '0;
        r_col  <= '0;
        i_row  <= '0;
        r_row  <= '0;
        w_idx  <= '0;
      end
      if (rd_acc) begin
        if (state == LOAD_IN) begin
          in_ptr <= in_ptr + 1'b1;
          i_col  <= i_col + 1'b1;
        end else if (i_col == NI) begin
          b_ptr <= b_ptr + 1'b1;
          i_col <= '0;
          i_row <= i_row + 1'b1;
        end else begin
          w_ptr <= w_ptr + 1'b1;
          i_col <= i_col + 1'b1;
        end
      end
      if (rv) begin
        if (state == LOAD_IN) begin
          in_bits[r_col] <= |readdata;
          if (r_col == NI1) begin
            r_col <= '0;
            i_col <= '0;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else if (is_bias) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (wr_acc) begin
        o_ptr <= o_ptr + 1'b1;
        w_idx <= w_idx + 1'b1;
      end
    end
  end

  // Result buffer is plain storage; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (mac_ov) out_buf[r_row] <= mac_out;
  end

  fc_mac_unit #(
    .DATA_W      (DATA_W),
    .ACC_W       (ACC_W),
    .BINARIZE_OUT(BINARIZE_OUT)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state == IDLE),
    .valid    (mac_v),
    .is_bias  (is_bias),
    .in_bit   (in_bit),
    .data     (readdata),
    .out_valid(mac_ov),
    .out_data (mac_out)
  );

endmodule

// File: tb/tb_fc_layer_master.sv
// Directed bench for fc_layer_master: threshold instance with an
// Avalon slave model, plus a saturating-mode instance.
module tb_fc_layer_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        start_a, busy_a, done_a;
  logic [31:0] inb_a, wb_a, bb_a, ob_a, address_a;
  logic [2:0]  s_a;
  logic        cs_a, read_n_a, write_n_a, wr_a, rdv_a;
  logic [1:0]  be_a;
  logic [15:0] rdd_a, wd_a;

  logic        start_b, busy_b, done_b;
  logic [31:0] inb_b, wb_b, bb_b, ob_b, address_b;
  logic [2:0]  s_b;
  logic        cs_b, read_n_b, write_n_b, wr_b, rdv_b;
  logic [1:0]  be_b;
  logic [15:0] rdd_b, wd_b;

  fc_layer_master #(
    .DATA_W(16), .ADDR_W(32), .N_IN(4), .N_OUT(2),
    .ACC_W(24), .MAX_OUTSTANDING(8), .BINARIZE_OUT(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .in_base(inb_a), .w_base(wb_a), .b_base(bb_a), .out_base(ob_a),
    .busy(busy_a), .done(done_a), .s(s_a), .address(address_a),
    .chipselect(cs_a), .read_n(read_n_a), .write_n(write_n_a),
    .byteenable(be_a), .waitrequest(wr_a), .readdata(rdd_a),
    .readdatavalid(rdv_a), .writedata(wd_a)
  );

  fc_layer_master #(
    .DATA_W(16), .ADDR_W(32), .N_IN(4), .N_OUT(1),
    .ACC_W(17), .MAX_OUTSTANDING(8), .BINARIZE_OUT(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .in_base(inb_b), .w_base(wb_b), .b_base(bb_b), .out_base(ob_b),
    .busy(busy_b), .done(done_b), .s(s_b), .address(address_b),
    .chipselect(cs_b), .read_n(read_n_b), .write_n(write_n_b),
    .byteenable(be_b), .waitrequest(wr_b), .readdata(rdd_b),
    .readdatavalid(rdv_b), .writedata(wd_b)
  );

  typedef struct { logic [11:0] a; int due; } rd_t;
  typedef struct { logic [31:0] a; logic [15:0] d; } wt_t;

  logic [15:0] mema [4096];
  logic [15:0] memb [256];
  rd_t  qa[$];
  wt_t  wla[$];
  wt_t  wlb[$];
  rd_t  ea;
  wt_t  ew;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_due = 0;
  int lat_a = 0;
  int fixlat = 0;
  bit rnd = 0;
  int ovf = 0;
  int unstable = 0;
  int dca = 0;
  int stale_seen = 0;
  bit prev_rd = 0;
  bit prev_wr = 0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_wd = '0;
  bit pend_b = 0;
  logic [7:0] padr_b = '0;

  // Slave for instance A: random stalls, in-order returns with latency.
  always @(negedge clk) begin
    cyc++;
    if (reset_n !== 1'b1) begin
      prev_rd = 0;
      prev_wr = 0;
    end else begin
      if (prev_rd && (read_n_a !== 1'b0 || address_a !== prev_addr))
        unstable++;
      if (prev_wr && (write_n_a !== 1'b0 || address_a !== prev_addr ||
                      wd_a !== prev_wd))
        unstable++;
    end
    wr_a = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (read_n_a === 1'b0 && !wr_a) begin
      lat_a = rnd ? $urandom_range(0, 6) : fixlat;
      ea.a = address_a[11:0];
      ea.due = cyc + 1 + lat_a;
      if (ea.due <= last_due) ea.due = last_due + 1;
      last_due = ea.due;
      qa.push_back(ea);
      if (qa.size() > 8) ovf++;
    end
    if (write_n_a === 1'b0 && !wr_a) begin
      ew.a = address_a;
      ew.d = wd_a;
      wla.push_back(ew);
    end
    prev_rd = read_n_a === 1'b0 && wr_a;
    prev_wr = write_n_a === 1'b0 && wr_a;
    prev_addr = address_a;
    prev_wd = wd_a;
    rdv_a = 1'b0;
    rdd_a = 16'($urandom);
    if (qa.size() > 0 && qa[0].due <= cyc) begin
      rdv_a = 1'b1;
      rdd_a = mema[qa[0].a];
      qa.pop_front();
      if (s_a == 3'd0) stale_seen++;
    end
  end

  // Slave for instance B: never stalls, one-cycle read latency.
  always @(negedge clk) begin
    rdv_b = pend_b;
    rdd_b = pend_b ? memb[padr_b] : 16'h0;
    pend_b = read_n_b === 1'b0 && reset_n === 1'b1;
    padr_b = address_b[7:0];
    if (write_n_b === 1'b0) begin
      ew.a = address_b;
      ew.d = wd_b;
      wlb.push_back(ew);
    end
  end

  always @(negedge clk) if (done_a === 1'b1) dca++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " read_n"}, 64'(read_n_a), 64'd1);
    chk({tag, " write_n"}, 64'(write_n_a), 64'd1);
    chk({tag, " cs"}, 64'(cs_a), 64'd1);
    chk({tag, " be"}, 64'(be_a), 64'h3);
    chk({tag, " addr"}, 64'(address_a), 64'd0);
    chk({tag, " wdata"}, 64'(wd_a), 64'd0);
    chk({tag, " busy"}, 64'(busy_a), 64'd0);
    chk({tag, " done"}, 64'(done_a), 64'd0);
    chk({tag, " s"}, 64'(s_a), 64'd0);
  endtask

  task automatic wait_done_a(input string tag);
    int n;
    int gap;
    n = 0;
    gap = 0;
    while (done_a !== 1'b1 && n < 3000) begin
      if (busy_a !== 1'b1) gap++;
      tick();
      n++;
    end
    chk({tag, " finished"}, 64'(n < 3000), 64'd1);
    chk({tag, " busy gap"}, 64'(gap), 64'd0);
    chk({tag, " busy at done"}, 64'(busy_a), 64'd0);
  endtask

  task automatic chk_wr_a(input string tag, input logic [31:0] obs,
                          input logic [15:0] e0, input logic [15:0] e1);
    logic [31:0] ea2;
    logic [15:0] ed;
    chk({tag, " nwrites"}, 64'(wla.size()), 64'd2);
    for (int j = 0; j < 2; j++) begin
      if (j < wla.size()) begin
        ea2 = obs + 32'(j);
        ed = (j == 0) ? e0 : e1;
        chk($sformatf("%s waddr%0d", tag, j), 64'(wla[j].a), 64'(ea2));
        chk($sformatf("%s wdata%0d", tag, j), 64'(wla[j].d), 64'(ed));
      end
    end
    wla.delete();
  endtask

  task automatic run_a(input string tag, input logic [31:0] ib,
                       input logic [31:0] wbs, input logic [31:0] bbs,
                       input logic [31:0] obs, input logic [15:0] e0,
                       input logic [15:0] e1);
    wla.delete();
    dca = 0;
    inb_a = ib;
    wb_a = wbs;
    bb_a = bbs;
    ob_a = obs;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, " busy after start"}, 64'(busy_a), 64'd1);
    wait_done_a(tag);
    tick();
    tick();
    chk({tag, " done pulses"}, 64'(dca), 64'd1);
    chk_wr_a(tag, obs, e0, e1);
  endtask

  task automatic run_b(input string tag, input logic [15:0] e);
    int n;
    wlb.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk({tag, " finished"}, 64'(n < 500), 64'd1);
    tick();
    chk({tag, " nwrites"}, 64'(wlb.size()), 64'd1);
    if (wlb.size() > 0) begin
      chk({tag, " waddr"}, 64'(wlb[0].a), 64'h40);
      chk({tag, " wdata"}, 64'(wlb[0].d), 64'(e));
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    wr_a = 1'b0;
    wr_b = 1'b0;
    rdv_a = 1'b0;
    rdv_b = 1'b0;
    rdd_a = '0;
    rdd_b = '0;
    inb_a = '0; wb_a = '0; bb_a = '0; ob_a = '0;
    inb_b = 32'h10; wb_b = 32'h20; bb_b = 32'h30; ob_b = 32'h40;
    for (int i = 0; i < 4096; i++) mema[i] = '0;
    for (int i = 0; i < 256; i++) memb[i] = '0;

    mema[12'h100] = 16'd1; mema[12'h101] = 16'd0;
    mema[12'h102] = 16'd5; mema[12'h103] = 16'd0;
    mema[12'h200] = 16'd3;    mema[12'h201] = 16'd9;
    mema[12'h202] = -16'sd2;  mema[12'h203] = 16'd7;
    mema[12'h204] = -16'sd4;  mema[12'h205] = 16'd1;
    mema[12'h206] = -16'sd1;  mema[12'h207] = 16'd2;
    mema[12'h300] = 16'd0;    mema[12'h301] = 16'd4;
    mema[12'hFFE] = 16'd1; mema[12'hFFF] = 16'd0;
    mema[12'h000] = 16'd5; mema[12'h001] = 16'd0;
    mema[12'h500] = 16'd0; mema[12'h501] = 16'd2;
    mema[12'h502] = 16'd0; mema[12'h503] = -16'sd1;
    mema[12'h600] = 16'd5; mema[12'h601] = -16'sd6;
    mema[12'h602] = 16'd8; mema[12'h603] = 16'd2;
    mema[12'h604] = 16'd0; mema[12'h605] = 16'd7;
    mema[12'h606] = 16'd0; mema[12'h607] = -16'sd3;
    mema[12'h680] = 16'd3; mema[12'h681] = -16'sd4;
    for (int i = 0; i < 4; i++) memb[8'h10 + i] = 16'd1;

    tick();
    tick();
    chk_reset_a("reset");
    chk("reset b s", 64'(s_b), 64'd0);
    chk("reset b busy", 64'(busy_b), 64'd0);
    chk("reset b cs/be", 64'({cs_b, be_b}), 64'h7);
    reset_n = 1'b1;
    tick();

    run_a("basic", 32'h100, 32'h200, 32'h300, 32'h400, 16'd1, 16'd0);

    rnd = 1;
    ovf = 0;
    unstable = 0;
    run_a("stall", 32'h100, 32'h200, 32'h300, 32'h400, 16'd1, 16'd0);
    run_a("wrap", 32'hFFFF_FFFE, 32'h200, 32'h300, 32'hFFFF_FFFF,
          16'd1, 16'd0);
    chk("outstanding bound", 64'(ovf), 64'd0);
    chk("stall stability", 64'(unstable), 64'd0);
    rnd = 0;

    fixlat = 6;
    inb_a = 32'h100; wb_a = 32'h200; bb_a = 32'h300; ob_a = 32'h400;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(s_a == 3'd2 && qa.size() == 5) && n < 300) begin
      tick();
      n++;
    end
    chk("reach 5 outstanding", 64'(n < 300), 64'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_a("midreset");
    tick();
    tick();
    reset_n = 1'b1;
    stale_seen = 0;
    n = 0;
    while (qa.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("stale pulses seen", 64'(stale_seen > 0), 64'd1);
    chk("idle after stale s", 64'(s_a), 64'd0);
    chk("idle after stale busy", 64'(busy_a), 64'd0);
    chk("idle after stale read_n", 64'(read_n_a), 64'd1);
    fixlat = 0;
    run_a("after reset", 32'h100, 32'h200, 32'h300, 32'h400,
          16'd1, 16'd0);

    wla.delete();
    dca = 0;
    inb_a = 32'h100; wb_a = 32'h200; bb_a = 32'h300; ob_a = 32'h400;
    start_a = 1'b1;
    tick();
    inb_a = 32'hDEAD; wb_a = 32'hBEEF; bb_a = 32'hCAFE; ob_a = 32'hF00D;
    wait_done_a("held1");
    inb_a = 32'h500; wb_a = 32'h600; bb_a = 32'h680; ob_a = 32'h780;
    tick();
    chk("held idle s", 64'(s_a), 64'd0);
    chk("held idle busy", 64'(busy_a), 64'd0);
    chk("held done pulses", 64'(dca), 64'd1);
    chk_wr_a("held1", 32'h400, 16'd1, 16'd0);
    tick();
    chk("held restart s", 64'(s_a), 64'd1);
    chk("held restart busy", 64'(busy_a), 64'd1);
    start_a = 1'b0;
    wait_done_a("held2");
    tick();
    chk_wr_a("held2", 32'h780, 16'd0, 16'd1);

    for (int i = 0; i < 4; i++) memb[8'h20 + i] = 16'h7FFF;
    memb[8'h30] = 16'h7FFF;
    run_b("sat pos", 16'h7FFF);
    for (int i = 0; i < 4; i++) memb[8'h20 + i] = 16'h8000;
    memb[8'h30] = 16'h8000;
    run_b("sat neg", 16'h8000);
    memb[8'h20] = 16'd100;
    memb[8'h21] = -16'sd50;
    memb[8'h22] = 16'd7;
    memb[8'h23] = 16'd0;
    memb[8'h30] = -16'sd60;
    run_b("plain neg", 16'hFFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_layer_master.md
Name: fc_layer_master

Overview:
Parametrised Avalon-MM master that computes one fully-connected layer with binary input activations in SDRAM. Flow: load an N_IN-word input vector, stream N_OUT rows of weights plus one bias per row, threshold or saturate each result, write N_OUT words back. Successor to the fixed 784/200 SDRAM layer engine. Adds runtime base addresses, pipelined reads with a bounded outstanding count, a saturating accumulator, and a selectable output mode.

Parameters:
DATA_W, 16, width of SDRAM data word (weights, bias, inputs, outputs)
ADDR_W, 32, word address width
N_IN, 784, inputs per neuron
N_OUT, 200, neurons in layer
ACC_W, 24, signed accumulator width (ACC_W >= DATA_W+1)
MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads
BINARIZE_OUT, 1, 1: write 0/1 sign of (acc+bias); 0: write (acc+bias) saturated to DATA_W

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE only
in_base  in  ADDR_W  word address of input vector; sampled at start
w_base  in  ADDR_W  weights, row-major, N_OUT*N_IN words
b_base  in  ADDR_W  biases, N_OUT words
out_base  in  ADDR_W  result destination, N_OUT words
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at completion
s  out  3  current state code
address  out  ADDR_W  Avalon word address
chipselect  out  1  Avalon chipselect
read_n  out  1  active-low read
write_n  out  1  active-low write
byteenable  out  DATA_W/8  always all ones
waitrequest  in  1  slave stall
readdata  in  DATA_W  signed read data
readdatavalid  in  1  read data strobe
writedata  out  DATA_W  write data

Behaviour:
- Reset values: read_n=1, write_n=1, chipselect=1, byteenable all ones, address=0, writedata=0, busy=0, done=0, s=IDLE. Internal counters, outstanding count and accumulator are cleared. Reset mid-operation aborts immediately. In-flight readdatavalid after reset is ignored.
- States: IDLE(0) -> LOAD_IN(1) -> MAC(2) -> WRITE(3) -> DONE(4) -> IDLE.
- IDLE: start=1 latches all four bases, sets busy, and moves to LOAD_IN. start while busy is ignored.
- Issue rule, all read phases: a read is accepted when read_n=0 and waitrequest=0. While waitrequest=1, address and read_n are held stable. A new read is issued only if outstanding < MAX_OUTSTANDING. outstanding increments on acceptance and decrements on readdatavalid. If both happen in the same cycle, outstanding is unchanged.
- LOAD_IN: reads in_base+0 .. in_base+N_IN-1. Returned word k stores bit in_bit[k] = (readdata != 0). Moves to MAC when N_IN words have returned. No weight reads overlap this phase.
- MAC: read sequence per row r is N_IN weights at w_base+r*N_IN+k, then bias at b_base+r. This gives N_OUT*(N_IN+1) reads total, issued back-to-back across row boundaries.
  - Weight return k: if in_bit[k], acc <= sat_ACC(acc + sext(readdata)); otherwise acc is unchanged.
  - Bias return: v = sat_ACC(acc + sext(bias)). Store out_buf[r] = BINARIZE_OUT ? (v<0 ? 0 : 1) : sat_DATA(v). Clear acc in the same cycle.
  - Data is consumed strictly in return order, which matches issue order.
  - Moves to WRITE after the last bias return, when outstanding is 0.
- WRITE: write_n=0, address=out_base+j, writedata=out_buf[j] for j=0..N_OUT-1. Advances only when waitrequest=0 and holds stable otherwise. After the last accepted write, moves to DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then returns to IDLE.
- Saturation: sat_ACC clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sat_DATA does the same for DATA_W.
- readdatavalid outside LOAD_IN/MAC is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Shared package fc_layer_pkg: state enum (IDLE..DONE, 3-bit), sat_add function parametrised by width, and the BINARIZE mode constants.
- Sub-module fc_mac_unit: accumulator, saturating add, bias/threshold, out_buf write strobe. Inputs are readdata/valid/is_bias/in_bit.
- The address and issue sequencer stays in the top level.

Test Plan:
- N_IN=4, N_OUT=2, no waitrequest, 1-cycle read latency. Inputs {1,0,5,0}, weights row0 {3,9,-2,7}, row1 {-4,1,-1,2}, biases {0,4} -> writes out_base+0=1 (sum 1), out_base+1=0 (sum -1); done pulses once.
- Same stimulus with random waitrequest and 0..6-cycle read latency -> identical writes. outstanding never exceeds MAX_OUTSTANDING, and address/read_n stay stable during every stall.
- BINARIZE_OUT=0, ACC_W=17, all inputs 1, weights 32767 x4, bias 32767 -> output 32767 (saturated).
- Mirror case with weights -32768 -> output -32768.
- Reset asserted mid-MAC with 5 reads outstanding, then late readdatavalid pulses, then start -> outputs at reset values, stale data ignored, second run produces correct results.
- start held high through a full run -> busy stays high, no restart until IDLE. A new run begins the cycle after DONE returns to IDLE, with fresh bases latched.
